gptp_ts_collect: RTL and testbench
==================================

# gptp_ts_collect

Egress-timestamp collector that sits directly downstream of the gPTP receive-to-send stage. It consumes that stage's single-cycle timestamp strobe (gptp_ts_rv_vaild / gptp_ts_rv_data), tags each timestamp with a running 16-bit sequence number, and buffers it in a small FIFO. Buffered entries are presented to the servo or CPU path through a valid/ready port. The block also counts dropped timestamps and flags timestamps that go backwards.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- LW, $clog2(DEPTH)+1, width of level output (derived, not overridden)
- clk  input  1  single clock for the whole block
- reset  input  1  synchronous, active-low reset
- gptp_ts_rv_vaild  input  1  one-cycle strobe; timestamp valid
- gptp_ts_rv_data  input  80  {epoch[79:64], sec[63:32], nanosec[31:0]}
- ts_out_vaild  output  1  FIFO head valid
- ts_out_ready  input  1  consumer accepts head
- ts_out_data  output  96  {seq[95:80], timestamp[79:0]} of head entry
- ts_fifo_level  output  LW  current occupancy, 0..DEPTH
- ts_ovf_cnt  output  16  dropped-timestamp count, saturates at 0xFFFF
- ts_order_err  output  1  sticky; non-increasing timestamp seen
- ts_clr  input  1  clears ts_ovf_cnt, ts_order_err, previous-sample tracking

## Operation
- Push: a cycle with gptp_ts_rv_vaild=1. Pop: a cycle with ts_out_vaild=1 and ts_out_ready=1.
- Every push is assigned the current seq, then seq increments by 1 (wraps 0xFFFF→0x0000). This applies whether the push is stored or dropped, so the consumer sees gaps in seq.
- Store rule: the entry is written if level<DEPTH, or if level==DEPTH and a pop happens in the same cycle. Otherwise the entry is dropped and ts_ovf_cnt increments, saturating at 0xFFFF.
- FIFO is first-word-fall-through. ts_out_data always shows the head entry. ts_out_data is don't-care when ts_out_vaild=0; the implementation holds the last value.
- Simultaneous push and pop: level is unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Order check: the 80-bit timestamp is compared as an unsigned value against the previous push (stored or dropped). If new ≤ previous, ts_order_err is set (sticky).
- The first push after reset or ts_clr has no previous sample and is never flagged.
- ts_clr: zeroes ts_ovf_cnt and ts_order_err and invalidates the previous sample. It does not flush the FIFO and does not reset seq.
  - If ts_clr coincides with an overflow or an order error, the clear wins and the event is not recorded.
  - A push in the same cycle as ts_clr still becomes the new previous sample.
- Backpressure toward upstream does not exist. The upstream strobe cannot be stalled, so drop-on-full is the only overflow policy.

## Timing
- Reset (reset=0 at posedge clk): ts_out_vaild=0, ts_out_data=0, ts_fifo_level=0, ts_ovf_cnt=0, ts_order_err=0, seq=0, pointers=0, previous-sample invalid.
- Reset asserted mid-operation discards all FIFO contents on that edge. Inputs are ignored while reset=0.
- Push at edge N into an empty FIFO: ts_out_vaild=1 and ts_out_data valid after edge N (one-cycle latency).
- Pop at edge N: the next head, if any, is visible after edge N. The consumer can pop every cycle.
- ts_fifo_level, ts_ovf_cnt and ts_order_err update on the same edge as the push or pop that causes the change.
- Back-to-back strobes (vaild high on consecutive cycles) are legal. Each cycle is a separate push.

## Test plan
- Reset then three strobes with ts=0x0000_00000001_00000010, …_00000020, …_00000030, ready=1 → out seq 0,1,2 in order, each one cycle after its strobe, level returns to 0, no error.
- ready=0, 10 strobes with increasing ts, DEPTH=8 → level=8, ts_ovf_cnt=2. Then drain with ready=1 → seq 0..7 emerge. Next strobe is tagged seq=10.
- FIFO full, strobe and pop in the same cycle → entry stored, level stays 8, ts_ovf_cnt unchanged.
- Strobe ts=0x…_00000100 then ts=0x…_00000100 (equal) → ts_order_err=1 after second edge. Then ts_clr=1 for one cycle → ts_order_err=0, ts_ovf_cnt=0, FIFO contents intact. A following smaller ts is not flagged.
- 65,537 strobes with ready=1 → seq wraps: the 65,537th entry has seq=0x0000.
- reset=0 for one cycle with 5 entries buffered → level=0, ts_out_vaild=0, seq=0 on the next push.

Source files
------------

// File: rtl/gptp_ts_collect_if.sv
// gptp_ts_collect_if: bundles the timestamp strobe input, the valid/ready
// output port and the status/clear signals of the egress timestamp collector.
// The collector itself connects through the slave modport; whatever drives
// the strobe and consumes the buffered entries uses the master modport.
interface gptp_ts_collect_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          gptp_ts_rv_vaild;
  logic [79:0]   gptp_ts_rv_data;
  logic          ts_out_vaild;
  logic          ts_out_ready;
  logic [95:0]   ts_out_data;
  logic [LW-1:0] ts_fifo_level;
  logic [15:0]   ts_ovf_cnt;
  logic          ts_order_err;
  logic          ts_clr;

  modport slave (
    input  gptp_ts_rv_vaild,
    input  gptp_ts_rv_data,
    input  ts_out_ready,
    input  ts_clr,
    output ts_out_vaild,
    output ts_out_data,
    output ts_fifo_level,
    output ts_ovf_cnt,
    output ts_order_err
  );

  modport master (
    output gptp_ts_rv_vaild,
    output gptp_ts_rv_data,
    output ts_out_ready,
    output ts_clr,
    input  ts_out_vaild,
    input  ts_out_data,
    input  ts_fifo_level,
    input  ts_ovf_cnt,
    input  ts_order_err
  );
endinterface

// File: rtl/gptp_ts_collect.sv
// gptp_ts_collect: tags each gPTP timestamp strobe with a running 16-bit
// sequence number and buffers it in a first-word-fall-through FIFO. The
// upstream strobe cannot be stalled, so a push into a full FIFO (with no pop
// in the same cycle) is dropped and counted. Timestamps that do not increase
// relative to the previous push set a sticky order error.
// DEPTH must be a power of two and at least 2, and must match the DEPTH of
// the connected interface instance.
module gptp_ts_collect #(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  gptp_ts_collect_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [95:0]   mem_q [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [95:0]   head_q, head_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   ovfCnt_q, ovfCnt_d;
  logic          orderErr_q, orderErr_d;
  logic [79:0]   prevTs_q, prevTs_d;
  logic          prevValid_q, prevValid_d;

  logic          pushReq;
  logic          popReq;
  logic          storeEn;
  logic          dropEv;
  logic          orderEv;
  logic [95:0]   newEntry;
  logic [LW-1:0] remaining;

  // FIFO bookkeeping: pointer/level updates and the next registered head entry.
  always_comb begin
    pushReq   = bus.gptp_ts_rv_vaild;
    popReq    = (level_q != '0) && bus.ts_out_ready;
    storeEn   = pushReq && ((level_q != FULL_LEVEL) || popReq);
    dropEv    = pushReq && !storeEn;
    newEntry  = {seq_q, bus.gptp_ts_rv_data};
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    head_d    = head_q;
    seq_d     = seq_q;

    if (storeEn) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popReq) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (pushReq) begin
      seq_d = seq_q + 16'd1;
    end

    remaining = level_q - {{(LW-1){1'b0}}, popReq};
    level_d   = remaining + {{(LW-1){1'b0}}, storeEn};

    // Entries still buffered after the pop are already in memory (the write
    // slot never aliases the new read slot since DEPTH >= 2); an empty FIFO
    // takes the incoming entry directly; otherwise the old head is held.
    if (remaining != '0) begin
      head_d = mem_q[rdPtr_d];
    end else if (storeEn) begin
      head_d = newEntry;
    end
  end

  // Drop counter, sticky order error and previous-sample tracking; a clear
  // overrides any event in the same cycle but a coincident push is retained.
  always_comb begin
    orderEv     = pushReq && prevValid_q && (bus.gptp_ts_rv_data <= prevTs_q);
    ovfCnt_d    = ovfCnt_q;
    orderErr_d  = orderErr_q;
    prevTs_d    = prevTs_q;
    prevValid_d = prevValid_q;

    if (bus.ts_clr) begin
      ovfCnt_d    = '0;
      orderErr_d  = 1'b0;
      prevValid_d = 1'b0;
    end else begin
      if (dropEv && (ovfCnt_q != 16'hFFFF)) begin
        ovfCnt_d = ovfCnt_q + 16'd1;
      end
      if (orderEv) begin
        orderErr_d = 1'b1;
      end
    end

    if (pushReq) begin
      prevTs_d    = bus.gptp_ts_rv_data;
      prevValid_d = 1'b1;
    end
  end

  // Storage array write; no reset needed since only occupied slots are read.
  always_ff @(posedge clk) begin
    if (reset && storeEn) begin
      mem_q[wrPtr_q] <= newEntry;
    end
  end

  // Control/status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      head_q      <= '0;
      seq_q       <= '0;
      ovfCnt_q    <= '0;
      orderErr_q  <= 1'b0;
      prevTs_q    <= '0;
      prevValid_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      seq_q       <= seq_d;
      ovfCnt_q    <= ovfCnt_d;
      orderErr_q  <= orderErr_d;
      prevTs_q    <= prevTs_d;
      prevValid_q <= prevValid_d;
    end
  end

  assign bus.ts_out_vaild  = (level_q != '0);
  assign bus.ts_out_data   = head_q;
  assign bus.ts_fifo_level = level_q;
  assign bus.ts_ovf_cnt    = ovfCnt_q;
  assign bus.ts_order_err  = orderErr_q;

endmodule

// File: tb/tb_gptp_ts_collect.sv
// tb_gptp_ts_collect: table of directed vectors with explicit expected
// outputs, a hand-written sequence-number wrap run, and a randomized run,
// all cross-checked against a queue-based reference model of the collector.
module tb_gptp_ts_collect;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gptp_ts_collect_if #(.DEPTH(DEPTH)) bus ();

  gptp_ts_collect #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state: a queue of {seq, ts} entries plus counters.
  logic [95:0] mQ[$];
  int unsigned mSeq;
  int unsigned mOvf;
  logic        mErr;
  logic        mPrevValid;
  logic [79:0] mPrevTs;
  logic [95:0] mHead;

  typedef struct {
    logic        v;
    logic [79:0] ts;
    logic        rdy;
    logic        clr;
    logic        rstn;
    logic        eValid;
    logic [15:0] eSeq;
    logic [3:0]  eLevel;
    logic [15:0] eOvf;
    logic        eErr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [79:0] mkTs(input logic [31:0] ns);
    return {16'h0000, 32'h0000_0001, ns};
  endfunction

  task automatic addVec(input logic v, input logic [79:0] ts, input logic rdy,
                        input logic clr, input logic rstn, input logic eValid,
                        input logic [15:0] eSeq, input logic [3:0] eLevel,
                        input logic [15:0] eOvf, input logic eErr);
    vec_t r;
    r.v = v; r.ts = ts; r.rdy = rdy; r.clr = clr; r.rstn = rstn;
    r.eValid = eValid; r.eSeq = eSeq; r.eLevel = eLevel;
    r.eOvf = eOvf; r.eErr = eErr;
    vecs.push_back(r);
  endtask

  // One clock edge of the collector's behaviour, computed from its rules.
  task automatic modelStep(input logic v, input logic [79:0] d, input logic rdy,
                           input logic clr, input logic rstn);
    bit popNow;
    bit lower;
    if (!rstn) begin
      mQ.delete();
      mSeq = 0; mOvf = 0; mErr = 1'b0;
      mPrevValid = 1'b0; mPrevTs = '0; mHead = '0;
      return;
    end
    popNow = (mQ.size() > 0) && rdy;
    if (popNow) void'(mQ.pop_front());
    lower = v && mPrevValid && (d <= mPrevTs);
    if (v) begin
      if (mQ.size() < DEPTH) mQ.push_back({mSeq[15:0], d});
      else if (mOvf < 65535) mOvf++;
      mSeq = (mSeq + 1) % 65536;
      mPrevTs = d;
      mPrevValid = 1'b1;
    end
    if (lower) mErr = 1'b1;
    if (clr) begin
      mOvf = 0;
      mErr = 1'b0;
      mPrevValid = v;
    end
    if (mQ.size() > 0) mHead = mQ[0];
  endtask

  task automatic checkField(input string name, input logic [95:0] act,
                            input logic [95:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
  task automatic applyStimulus(input logic v, input logic [79:0] d, input logic rdy,
                               input logic clr, input logic rstn);
    bus.gptp_ts_rv_vaild = v;
    bus.gptp_ts_rv_data  = d;
    bus.ts_out_ready     = rdy;
    bus.ts_clr           = clr;
    reset                = rstn;
    modelStep(v, d, rdy, clr, rstn);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkField({tag, ".valid"}, 96'(bus.ts_out_vaild), 96'(mQ.size() > 0));
    checkField({tag, ".level"}, 96'(bus.ts_fifo_level), 96'(mQ.size()));
    checkField({tag, ".ovf"},   96'(bus.ts_ovf_cnt), 96'(mOvf));
    checkField({tag, ".err"},   96'(bus.ts_order_err), 96'(mErr));
    checkField({tag, ".data"},  bus.ts_out_data, mHead);
  endtask

  initial begin
    logic [79:0] curTs;
    int          readyPct;
    logic        rv, rr, rc, rn;

    bus.gptp_ts_rv_vaild = 1'b0;
    bus.gptp_ts_rv_data  = '0;
    bus.ts_out_ready     = 1'b0;
    bus.ts_clr           = 1'b0;
    reset                = 1'b0;

    // Directed table: basic flow, overflow, full+pop, clear, order, mid-run reset.
    addVec(0, '0, 0, 0, 0,  0, 0, 0, 0, 0);
    addVec(1, mkTs(32'h10), 1, 0, 1,  1, 0, 1, 0, 0);
    addVec(1, mkTs(32'h20), 1, 0, 1,  1, 1, 1, 0, 0);
    addVec(1, mkTs(32'h30), 1, 0, 1,  1, 2, 1, 0, 0);
    addVec(0, '0, 1, 0, 1,  0, 0, 0, 0, 0);

    addVec(0, '0, 0, 0, 0,  0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      addVec(1, mkTs(32'h100 + 32'(i * 16)), 0, 0, 1,
             1, 0, 4'((i < 8) ? i + 1 : 8), 16'((i < 8) ? 0 : i - 7), 0);
    for (int k = 1; k <= 8; k++)
      addVec(0, '0, 1, 0, 1,  (k < 8), 16'(k), 4'(8 - k), 2, 0);
    addVec(1, mkTs(32'h200), 0, 0, 1,  1, 10, 1, 2, 0);

    for (int i = 0; i < 7; i++)
      addVec(1, mkTs(32'h210 + 32'(i * 16)), 0, 0, 1,  1, 10, 4'(i + 2), 2, 0);
    addVec(1, mkTs(32'h300), 0, 0, 1,  1, 10, 8, 3, 0);
    addVec(1, mkTs(32'h310), 1, 0, 1,  1, 11, 8, 3, 0);
    addVec(0, '0, 0, 1, 1,  1, 11, 8, 0, 0);
    addVec(1, mkTs(32'h320), 0, 1, 1,  1, 11, 8, 0, 0);

    addVec(0, '0, 0, 0, 0,  0, 0, 0, 0, 0);
    addVec(1, mkTs(32'h100), 0, 0, 1,  1, 0, 1, 0, 0);
    addVec(1, mkTs(32'h100), 0, 0, 1,  1, 0, 2, 0, 1);
    addVec(0, '0, 0, 1, 1,  1, 0, 2, 0, 0);
    addVec(1, mkTs(32'h50), 0, 0, 1,  1, 0, 3, 0, 0);
    addVec(1, mkTs(32'h40), 0, 0, 1,  1, 0, 4, 0, 1);
    addVec(1, mkTs(32'h30), 0, 1, 1,  1, 0, 5, 0, 0);
    addVec(1, mkTs(32'h20), 0, 0, 1,  1, 0, 6, 0, 1);

    addVec(0, '0, 0, 0, 0,  0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec(1, mkTs(32'h400 + 32'(i)), 0, 0, 1,  1, 0, 4'(i + 1), 0, 0);
    addVec(0, '0, 0, 0, 0,  0, 0, 0, 0, 0);
    addVec(1, mkTs(32'h500), 0, 0, 1,  1, 0, 1, 0, 0);
    addVec(1, {16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 0, 0, 1,  1, 0, 2, 0, 0);
    addVec(1, {16'h0001, 32'h0, 32'h0}, 0, 0, 1,  1, 0, 3, 0, 0);
    addVec(1, {16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 0, 0, 1,  1, 0, 4, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      applyStimulus(vecs[i].v, vecs[i].ts, vecs[i].rdy, vecs[i].clr, vecs[i].rstn);
      checkField({tag, ".tvalid"}, 96'(bus.ts_out_vaild), 96'(vecs[i].eValid));
      checkField({tag, ".tlevel"}, 96'(bus.ts_fifo_level), 96'(vecs[i].eLevel));
      checkField({tag, ".tovf"},   96'(bus.ts_ovf_cnt), 96'(vecs[i].eOvf));
      checkField({tag, ".terr"},   96'(bus.ts_order_err), 96'(vecs[i].eErr));
      if (vecs[i].eValid)
        checkField({tag, ".tseq"}, 96'(bus.ts_out_data[95:80]), 96'(vecs[i].eSeq));
      checkOutput(tag);
    end

    // Sequence number wrap: 65,537 back-to-back strobes with ready held high.
    applyStimulus(0, '0, 1, 0, 0);
    for (int n = 0; n < 65537; n++) begin
      applyStimulus(1, mkTs(32'(n + 1)), 1, 0, 1);
      if (n == 65535)
        checkField("wrapSeqFFFF", 96'(bus.ts_out_data[95:80]), 96'h0000_FFFF);
    end
    checkField("wrapValid", 96'(bus.ts_out_vaild), 96'd1);
    checkField("wrapSeq0",  96'(bus.ts_out_data[95:80]), 96'd0);
    checkField("wrapErr",   96'(bus.ts_order_err), 96'd0);
    checkOutput("wrap");

    // Randomized traffic with varying consumer throughput against the model.
    applyStimulus(0, '0, 0, 0, 0);
    curTs    = mkTs(32'h1000);
    readyPct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) readyPct = int'($urandom_range(10, 90));
      case ($urandom_range(0, 19))
        0:       curTs = {16'($urandom), $urandom, $urandom};
        1:       curTs = curTs;
        default: curTs = curTs + 80'($urandom_range(1, 1000));
      endcase
      rv = ($urandom_range(0, 9) < 7);
      rr = (int'($urandom_range(0, 99)) < readyPct);
      rc = ($urandom_range(0, 49) == 0);
      rn = ($urandom_range(0, 299) != 0);
      applyStimulus(rv, curTs, rr, rc, rn);
      checkOutput($sformatf("r%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
